// File: rtl/branch_resolve_unit.sv
// Branch resolution: compare A/B under control, pick next PC, flag mispredicts; optional stats (BRANCH_STATS_EN).
// Latency 2 cycles accept->out_valid, one result per cycle when unstalled.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready drops once S1 is also full; flush keeps in_ready high.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      control,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_taken,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_mispredict
`endif
);

    logic            s1_valid_q, s1_valid_d;
    logic            s1_taken_q, s1_taken_d;
    logic            s1_pred_q, s1_pred_d;
    logic            s1_illegal_q, s1_illegal_d;
    logic [XLEN-1:0] s1_tgt_q, s1_tgt_d;
    logic [XLEN-1:0] s1_seq_q, s1_seq_d;

    logic            out_valid_q, out_valid_d;
    logic            out_taken_q, out_taken_d;
    logic            out_mispredict_q, out_mispredict_d;
    logic            out_illegal_q, out_illegal_d;
    logic [XLEN-1:0] out_target_q, out_target_d;

    logic cmp_taken, cmp_illegal;
    logic s2_load, accept;

    always_comb begin
        cmp_taken   = 1'b0;
        cmp_illegal = 1'b0;
        case (control)
            4'b0000: cmp_taken = (A == B);
            4'b0001: cmp_taken = (A != B);
            4'b0010: cmp_taken = ($signed(A) <  $signed(B));
            4'b0011: cmp_taken = ($signed(A) >= $signed(B));
            4'b0100: cmp_taken = (A <  B);
            4'b0101: cmp_taken = (A >= B);
            default: cmp_illegal = 1'b1;
        endcase
    end

    // flush wins over everything, and the producer is never stalled while it is asserted
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = flush || !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_taken_d   = s1_taken_q;
        s1_pred_d    = s1_pred_q;
        s1_illegal_d = s1_illegal_q;
        s1_tgt_d     = s1_tgt_q;
        s1_seq_d     = s1_seq_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d   = 1'b1;
            s1_taken_d   = cmp_taken;
            s1_pred_d    = pred_taken;
            s1_illegal_d = cmp_illegal;
            s1_tgt_d     = pc + imm;
            s1_seq_d     = pc + XLEN'(4);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_mispredict_d = out_mispredict_q;
        out_illegal_d    = out_illegal_q;
        out_target_d     = out_target_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_taken_d      = s1_taken_q;
                out_mispredict_d = s1_taken_q != s1_pred_q;
                out_illegal_d    = s1_illegal_q;
                out_target_d     = s1_taken_q ? s1_tgt_q : s1_seq_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_taken_q       <= 1'b0;
            s1_pred_q        <= 1'b0;
            s1_illegal_q     <= 1'b0;
            s1_tgt_q         <= '0;
            s1_seq_q         <= '0;
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            out_target_q     <= '0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_taken_q       <= s1_taken_d;
            s1_pred_q        <= s1_pred_d;
            s1_illegal_q     <= s1_illegal_d;
            s1_tgt_q         <= s1_tgt_d;
            s1_seq_q         <= s1_seq_d;
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_mispredict_q <= out_mispredict_d;
            out_illegal_q    <= out_illegal_d;
            out_target_q     <= out_target_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_mispredict = out_mispredict_q;
    assign out_illegal    = out_illegal_q;
    assign out_target     = out_target_q;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_branches_q, stat_branches_d;
    logic [CNT_W-1:0] stat_taken_q, stat_taken_d;
    logic [CNT_W-1:0] stat_mispredict_q, stat_mispredict_d;
    logic             out_hs;

    // a result discarded by a same-cycle flush is not considered delivered
    assign out_hs = out_valid_q && out_ready && !flush;

    always_comb begin
        stat_branches_d   = stat_branches_q;
        stat_taken_d      = stat_taken_q;
        stat_mispredict_d = stat_mispredict_q;
        if (out_hs) begin
            if (stat_branches_q != '1)
                stat_branches_d = stat_branches_q + CNT_W'(1);
            if (out_taken_q && stat_taken_q != '1)
                stat_taken_d = stat_taken_q + CNT_W'(1);
            if (out_mispredict_q && stat_mispredict_q != '1)
                stat_mispredict_d = stat_mispredict_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q   <= '0;
            stat_taken_q      <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_branches_q   <= stat_branches_d;
            stat_taken_q      <= stat_taken_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end

    assign stat_branches   = stat_branches_q;
    assign stat_taken      = stat_taken_q;
    assign stat_mispredict = stat_mispredict_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus randomized traffic against a reference model.
module tb_branch_resolve_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      control = '0;
    logic [XLEN-1:0] A = '0, B = '0, pc = '0, imm = '0;
    logic            pred_taken = 1'b0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_mispredict;
    logic            out_illegal;
`ifdef BRANCH_STATS_EN
    logic [3:0] stat_branches, stat_taken, stat_mispredict;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mis;
        logic            ill;
    } res_t;

`ifdef BRANCH_STATS_EN
    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(4)) dut (
`else
    branch_resolve_unit #(.XLEN(XLEN)) dut (
`endif
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .A(A), .B(B), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_mispredict(out_mispredict), .out_illegal(out_illegal)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    // Reference: the architectural rules for a single branch, no notion of pipeline.
    function automatic res_t model(input logic [3:0] c, input logic [XLEN-1:0] a, b, p, i,
                                   input logic pr);
        res_t r;
        r.ill = (c > 4'd5);
        case (c)
            4'd0: r.taken = (a == b);
            4'd1: r.taken = (a != b);
            4'd2: r.taken = (int'(a) <  int'(b));
            4'd3: r.taken = (int'(a) >= int'(b));
            4'd4: r.taken = (a <  b);
            4'd5: r.taken = (a >= b);
            default: r.taken = 1'b0;
        endcase
        r.target = r.taken ? XLEN'(p + i) : XLEN'(p + 32'd4);
        r.mis = (r.taken != pr);
        return r;
    endfunction

    function automatic res_t observed();
        return '{taken: out_taken, target: out_target, mis: out_mispredict, ill: out_illegal};
    endfunction

    task automatic set_req(input logic [3:0] c, input logic [XLEN-1:0] a, b, p, i, input logic pr);
        control = c; A = a; B = b; pc = p; imm = i; pred_taken = pr;
    endtask

    // Sends one request with out_ready high; returns the result and cycles from accept to out_valid.
    task automatic send_one(input logic [3:0] c, input logic [XLEN-1:0] a, b, p, i,
                            input logic pr, output res_t r, output int lat);
        int n;
        @(negedge clk);
        set_req(c, a, b, p, i, pr);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk); lat++;
        end
        if (!out_valid) lat = -1;
        r = observed();
    endtask

    task automatic test_reset();
        res_t r;
        int   lat;
        #12;
        n_checks++;
        if ({out_valid, out_taken, out_mispredict, out_illegal} !== 4'b0 || out_target !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b t=%b m=%b i=%b tgt=%h, expected all zero",
                     out_valid, out_taken, out_mispredict, out_illegal, out_target);
        end
        @(negedge clk); rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        // Fill the pipe with two entries, then reset asynchronously mid-cycle.
        send_one(4'd0, 32'd3, 32'd3, 32'h100, 32'h20, 1'b0, r, lat);
        out_ready = 1'b0;
        n_checks++;
        if (r.target !== 32'h120) begin
            n_fail++; $display("FAIL reset_pre_target: got %h expected 00000120", r.target);
        end
        in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #2; rst = 1'b1; #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_target !== '0) begin
            n_fail++; $display("FAIL reset_async: got v=%b tgt=%h expected v=0 tgt=0", out_valid, out_target);
        end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_after_in_ready: got %b expected 1", in_ready);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_dropped: got out_valid=%b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0]  ctl [6] = '{4'd2, 4'd4, 4'd3, 4'd5, 4'd0, 4'd1};
        logic [31:0] av  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5};
        logic [31:0] bv  [6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5};
        logic        exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        res_t r;
        int   lat;
        for (int k = 0; k < 6; k++) begin
            send_one(ctl[k], av[k], bv[k], 32'h1000, 32'h40, 1'b0, r, lat);
            n_checks++;
            if (lat !== 2) begin
                n_fail++; $display("FAIL cmp_latency[%0d]: got %0d expected 2", k, lat);
            end
            n_checks++;
            if (r.taken !== exp[k] || r.mis !== exp[k] || r.ill !== 1'b0 ||
                r.target !== (exp[k] ? 32'h1040 : 32'h1004)) begin
                n_fail++;
                $display("FAIL cmp_result[%0d]: got t=%b m=%b i=%b tgt=%h expected t=%b m=%b i=0 tgt=%h",
                         k, r.taken, r.mis, r.ill, r.target, exp[k], exp[k],
                         exp[k] ? 32'h1040 : 32'h1004);
            end
        end
    endtask

    task automatic test_wrap();
        res_t r;
        int   lat;
        send_one(4'd0, 32'd7, 32'd7, 32'hFFFFFFFC, 32'd8, 1'b1, r, lat);
        n_checks++;
        if (r.taken !== 1'b1 || r.target !== 32'h00000004) begin
            n_fail++; $display("FAIL wrap_taken: got t=%b tgt=%h expected t=1 tgt=00000004", r.taken, r.target);
        end
        send_one(4'd0, 32'd7, 32'd6, 32'hFFFFFFFC, 32'd8, 1'b1, r, lat);
        n_checks++;
        if (r.taken !== 1'b0 || r.target !== 32'h00000000 || r.mis !== 1'b1) begin
            n_fail++; $display("FAIL wrap_not_taken: got t=%b tgt=%h m=%b expected t=0 tgt=00000000 m=1",
                               r.taken, r.target, r.mis);
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t req_r, cur, prev;
        logic [3:0]  rc [4];
        logic [31:0] ra [4], rb [4], rp [4];
        logic prev_stall = 1'b0;
        int sent = 0, got = 0;
        for (int k = 0; k < 4; k++) begin
            rc[k] = 4'(k % 6); ra[k] = $urandom; rb[k] = (k % 2) ? ra[k] : $urandom;
            rp[k] = $urandom & 32'hFFFFFFFC;
        end
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid = (sent < 4);
            if (sent < 4) set_req(rc[sent], ra[sent], rb[sent], rp[sent], 32'h10 << sent, sent[0]);
            #1;
            cur = observed();
            if (c == 4) begin
                n_checks++;
                if (in_ready !== 1'b0 || sent !== 2) begin
                    n_fail++; $display("FAIL b2b_stall: got in_ready=%b accepted=%0d expected 0 and 2", in_ready, sent);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    n_fail++; $display("FAIL b2b_hold: got v=%b %h expected v=1 %h", out_valid, cur, prev);
                end
            end
            if (out_valid && out_ready) begin
                req_r = exp_q.pop_front();
                n_checks++;
                if (cur !== req_r) begin
                    n_fail++; $display("FAIL b2b_order[%0d]: got %h expected %h", got, cur, req_r);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(control, A, B, pc, imm, pred_taken));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev = cur;
        end
        @(negedge clk); in_valid = 1'b0;
        n_checks++;
        if (got !== 4 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_count: got %0d results (out_valid=%b) expected 4 and 0", got, out_valid);
        end
    endtask

    task automatic test_flush();
        res_t r;
        int   lat;
        logic leak = 1'b0;
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1;
        set_req(4'd0, 32'd1, 32'd1, 32'h200, 32'h8, 1'b0);
        @(negedge clk); set_req(4'd1, 32'd1, 32'd2, 32'h300, 32'h8, 1'b0);
        @(negedge clk); set_req(4'd0, 32'd9, 32'd9, 32'h400, 32'h8, 1'b1); flush = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got out_valid=%b expected 0", out_valid);
        end
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) leak = 1'b1;
        end
        n_checks++;
        if (leak !== 1'b0) begin
            n_fail++; $display("FAIL flush_leak: got a result after flush, expected none");
        end
        send_one(4'd2, 32'h5, 32'hFFFFFFF0, 32'h500, 32'hFFFFFF00, 1'b1, r, lat);
        n_checks++;
        if (lat !== 2 || r !== model(4'd2, 32'h5, 32'hFFFFFFF0, 32'h500, 32'hFFFFFF00, 1'b1)) begin
            n_fail++; $display("FAIL flush_next: got lat=%0d %h expected lat=2 %h", lat, r,
                               model(4'd2, 32'h5, 32'hFFFFFFF0, 32'h500, 32'hFFFFFF00, 1'b1));
        end
    endtask

    task automatic test_illegal();
        res_t r;
        int   lat;
        send_one(4'b0111, 32'd4, 32'd4, 32'h800, 32'h40, 1'b1, r, lat);
        n_checks++;
        if (r.ill !== 1'b1 || r.taken !== 1'b0 || r.mis !== 1'b1 || r.target !== 32'h804) begin
            n_fail++; $display("FAIL illegal: got i=%b t=%b m=%b tgt=%h expected i=1 t=0 m=1 tgt=00000804",
                               r.ill, r.taken, r.mis, r.target);
        end
    endtask

    task automatic test_random();
        res_t exp_q[$];
        res_t cur, e, prev;
        logic prev_stall = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            A = $urandom;
            set_req(4'($urandom_range(0, 15)), A, ($urandom_range(0, 3) == 0) ? A : $urandom,
                    $urandom, $urandom, 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            cur = observed();
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    n_fail++; $display("FAIL rand_hold: got v=%b %h expected v=1 %h", out_valid, cur, prev);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got result %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++; $display("FAIL rand_result: got %h expected %h", cur, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(control, A, B, pc, imm, pred_taken));
            prev_stall = out_valid && !out_ready;
            prev = cur;
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin
                cur = observed();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra: got result %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++; $display("FAIL rand_result: got %h expected %h", cur, e);
                    end
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_lost: got %0d results missing expected 0", exp_q.size());
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        res_t r;
        int   lat;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if ({stat_branches, stat_taken, stat_mispredict} !== 12'h0) begin
            n_fail++; $display("FAIL stats_reset: got %h %h %h expected 0 0 0",
                               stat_branches, stat_taken, stat_mispredict);
        end
        for (int k = 0; k < 20; k++) send_one(4'd0, 32'd1, 32'd1, 32'h40, 32'h4, 1'b1, r, lat);
        @(negedge clk);
        n_checks++;
        if (stat_taken !== 4'hF || stat_branches !== 4'hF || stat_mispredict !== 4'h0) begin
            n_fail++; $display("FAIL stats_sat: got br=%h tk=%h mp=%h expected F F 0",
                               stat_branches, stat_taken, stat_mispredict);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_compare();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
